alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Derived SHW = log2(WIDTH), shift-amount width; SHALL NOT be overridable.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; accepted only on a clk edge where start=1 and busy=0.
REQ-006 op  input  4  operation code, captured at accept.
REQ-007 X  input  WIDTH  operand A, captured at accept.
REQ-008 Y  input  WIDTH  operand B, captured at accept.
REQ-009 r  output  WIDTH  registered result, held until next completion.
REQ-010 zero  output  1  registered; 1 when r == 0, updated with r.
REQ-011 err  output  1  registered; 1 when the completed op code was undefined.
REQ-012 busy  output  1  1 while a multiply is in progress.
REQ-013 done  output  1  one-cycle pulse marking the cycle r/zero/err first show a new result.

Function
REQ-014 Op codes SHALL be: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 15 PASS (r=X), 3 SLL, 4 SRL, 5 SRA, 8 MUL.
REQ-015 ADD/SUB SHALL be modulo 2^WIDTH; carry/borrow discarded.
REQ-016 SLT SHALL be an unsigned compare: r = {WIDTH-1 zeros, (X<Y)}.
REQ-017 SLL/SRL/SRA SHALL shift X by Y[SHW-1:0]; upper Y bits ignored; SRA replicates X[WIDTH-1].
REQ-018 MUL SHALL return the low WIDTH bits of X*Y, unsigned, via iterative shift-add, one bit of Y per cycle.
REQ-019 Undefined codes (9,10,11,13,14) SHALL complete as single-cycle ops with r=0, zero=1, err=1.
REQ-020 err SHALL be 0 on every defined-op completion.
REQ-021 FSM states SHALL be IDLE, MUL, DONE.
REQ-022 IDLE: accept of non-MUL op -> DONE; result registered at that edge.
REQ-023 IDLE: accept of MUL -> MUL; load operands, clear accumulator, counter = WIDTH.
REQ-024 MUL: each cycle add shifted multiplicand if current Y bit = 1, decrement counter; at counter==1 register result and -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE; start in DONE SHALL be accepted (busy=0) and handled as from IDLE.
REQ-026 Latency: non-MUL done 1 cycle after accept edge; MUL done WIDTH+1 cycles after accept edge.
REQ-027 busy SHALL be 1 exactly in MUL; start while busy=1 SHALL be ignored, not queued.
REQ-028 Operand changes on X/Y/op after accept SHALL NOT affect the in-flight result.
REQ-029 r/zero/err SHALL change only at completion edges; all other cycles hold.

Reset
REQ-030 rst_n=0 SHALL immediately, without clk, force state IDLE, r=0, zero=1, err=0, busy=0, done=0, counter=0, accumulator=0.
REQ-031 Reset asserted mid-MUL SHALL abort the operation; no done pulse follows release.
REQ-032 First accept SHALL be possible on the first clk edge after rst_n rises.

Verification
REQ-033 WIDTH=32: start, op=2, X=0xFFFFFFFF, Y=1 -> next cycle done=1, r=0, zero=1, err=0.
REQ-034 op=6, X=3, Y=5 -> r=0xFFFFFFFE; op=7 same operands -> r=1; op=5, X=0x80000000, Y=0x24 -> r=0xF8000000.
REQ-035 op=8, X=0x10001, Y=0x10001 -> busy=1 for 32 cycles, done on cycle 33, r=0x00020001; start pulses during busy ignored.
REQ-036 op=11, X=7, Y=9 -> done after 1 cycle, r=0, zero=1, err=1; next op=0 with X=Y=0xF0 -> r=0xF0, err=0.
REQ-037 rst_n low at MUL cycle 10 -> outputs at reset values asynchronously, no done after release; new op=1 accepted on first edge.
REQ-038 WIDTH=8: op=8, X=0xFF, Y=0xFF -> done 9 cycles after accept, r=0x01; op=3, Y=0x0B -> shift by 3.

Source files
------------

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle ALU.
// Single-cycle ops (logic, add/sub, compare, shifts, pass) complete one cycle
// after accept. MUL uses a shift-add loop that consumes one multiplier bit
// per cycle and completes WIDTH+1 cycles after accept.
//
// Ports
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted when start=1 and busy=0
//   op     : operation code, captured at accept
//   X, Y   : operands A and B, captured at accept
//   r      : registered result, held until the next completion
//   zero   : registered, 1 when r == 0
//   err    : registered, 1 when the completed op code was undefined
//   busy   : 1 while a multiply is in progress
//   done   : one-cycle pulse, first cycle a new result is visible
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic             done
);

  // WIDTH is expected to be a power of two in 8..64.
  localparam int unsigned SHW = $clog2(WIDTH);
  // Counter must hold the value WIDTH itself.
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_result_nxt;
  logic             w_zero_nxt;
  logic             w_err_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_mplr_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_cnt_last;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_err;
  logic [WIDTH-1:0] w_step;

  // DONE accepts like IDLE; only MUL blocks a request.
  assign w_accept   = start && (r_state != ST_MUL);
  assign w_is_mul   = (op == OP_MUL);
  assign w_cnt_last = (r_cnt == CW'(1));
  assign w_shamt    = Y[SHW-1:0];

  // One shift-add step: add the shifted multiplicand when the current Y bit is set.
  assign w_step = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

  // Single-cycle result, taken straight from the inputs at the accept edge.
  always_comb begin
    w_alu_res = '0;
    w_alu_err = 1'b0;
    case (op)
      OP_AND:  w_alu_res = X & Y;
      OP_OR:   w_alu_res = X | Y;
      OP_ADD:  w_alu_res = X + Y;
      OP_SUB:  w_alu_res = X - Y;
      OP_SLT:  w_alu_res = WIDTH'(X < Y);
      OP_NOR:  w_alu_res = ~(X | Y);
      OP_PASS: w_alu_res = X;
      OP_SLL:  w_alu_res = X << w_shamt;
      OP_SRL:  w_alu_res = X >> w_shamt;
      OP_SRA:  w_alu_res = WIDTH'($signed(X) >>> w_shamt);
      OP_MUL:  w_alu_res = '0;
      default: w_alu_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless updated here.
  always_comb begin
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_err_nxt    = r_err;
    w_mcand_nxt  = r_mcand;
    w_mplr_nxt   = r_mplr;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = (w_state_nxt == ST_MUL);
    w_done_nxt   = (w_state_nxt == ST_DONE);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_mcand_nxt = X;
            w_mplr_nxt  = Y;
            w_acc_nxt   = '0;
            w_cnt_nxt   = CW'(WIDTH);
          end else begin
            w_result_nxt = w_alu_res;
            w_zero_nxt   = (w_alu_res == '0);
            w_err_nxt    = w_alu_err;
          end
        end
      end
      ST_MUL: begin
        w_acc_nxt   = w_step;
        w_mcand_nxt = {r_mcand[WIDTH-2:0], 1'b0};
        w_mplr_nxt  = {1'b0, r_mplr[WIDTH-1:1]};
        w_cnt_nxt   = r_cnt - CW'(1);
        if (w_cnt_last) begin
          w_result_nxt = w_step;
          w_zero_nxt   = (w_step == '0);
          w_err_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplr   <= w_mplr_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign r    = r_result;
  assign zero = r_zero;
  assign err  = r_err;
  assign busy = r_busy;
  assign done = r_done;

endmodule
